// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT sample buffer blocks.
package fft_pkg;
  localparam int N_WORDS = 512;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = $clog2(N_WORDS);

  typedef enum logic [1:0] {FILL, START, WAIT_DONE} loader_state_t;

  typedef logic [N_WORDS-1:0][DATA_W-1:0] frame_t;
endpackage

// File: rtl/fft_bitrev_addr.sv
// Word index to buffer address; optionally bit-reverses the complex point
// index while keeping the real/imag select in bit 0.
module fft_bitrev_addr #(
  parameter int ADDR_W      = fft_pkg::ADDR_W,
  parameter int BIT_REVERSE = 0
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] addr
);
  generate
    if (BIT_REVERSE != 0) begin : g_rev
      assign addr[0] = idx[0];
      for (genvar k = 1; k < ADDR_W; k++) begin : g_bit
        assign addr[k] = idx[ADDR_W-k];
      end
    end else begin : g_lin
      assign addr = idx;
    end
  endgenerate
endmodule

// File: rtl/fft_frame_loader.sv
// Assembles a serial sample stream into the FFT core's frame buffer and
// hands the frame off with a one-cycle start, holding it until done.
module fft_frame_loader #(
  parameter int N_WORDS     = fft_pkg::N_WORDS,
  parameter int DATA_W      = fft_pkg::DATA_W,
  parameter int BIT_REVERSE = 0,
  localparam int ADDR_W     = $clog2(N_WORDS)
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [DATA_W-1:0]                sample_in,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic                             frame_restart,
  input  logic                             fft_done,
  output logic                             fft_start,
  output logic                             busy,
  output logic [ADDR_W:0]                  samples_loaded_count,
  output logic [N_WORDS-1:0][DATA_W-1:0]   main_data
);
  import fft_pkg::*;

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  loader_state_t     state, state_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic              hs, clr;

  fft_bitrev_addr #(.ADDR_W(ADDR_W), .BIT_REVERSE(BIT_REVERSE)) u_addr (
    .idx  (count[ADDR_W-1:0]),
    .addr (addr)
  );

  // Restart beats a same-cycle handshake so a discarded word is never written.
  assign hs  = (state == FILL) && sample_valid && !frame_restart;
  assign clr = ((state == FILL) && frame_restart) || ((state == WAIT_DONE) && fft_done);
  assign samples_loaded_count = count;

  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    fft_start    = 1'b0;
    busy         = 1'b0;
    case (state)
      FILL: begin
        sample_ready = 1'b1;
        if (hs && (count[ADDR_W-1:0] == '1)) state_nxt = START;
      end
      START: begin
        fft_start = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (fft_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= FILL;
      count     <= '0;
      main_data <= '0;
    end else begin
      state <= state_nxt;
      if (clr)     count <= '0;
      else if (hs) count <= count + CNT_ONE;
      if (hs) main_data[addr] <= sample_in;
    end
  end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench: linear and bit-reversed loaders driven side by side.
module tb_fft_frame_loader;
  localparam int NW = 512;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic n_rst;
  logic [DW-1:0] sample_in;
  logic sample_valid, frame_restart, fft_done;
  logic ready0, start0, busy0, ready1, start1, busy1;
  logic [9:0] cnt0, cnt1;
  logic [NW-1:0][DW-1:0] md0, md1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_frame_loader #(.N_WORDS(NW), .DATA_W(DW), .BIT_REVERSE(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(ready0), .frame_restart(frame_restart), .fft_done(fft_done),
    .fft_start(start0), .busy(busy0), .samples_loaded_count(cnt0), .main_data(md0));

  fft_frame_loader #(.N_WORDS(NW), .DATA_W(DW), .BIT_REVERSE(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(ready1), .frame_restart(frame_restart), .fft_done(fft_done),
    .fft_start(start1), .busy(busy1), .samples_loaded_count(cnt1), .main_data(md1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev_addr(input int k);
    int r;
    r = k & 1;
    for (int b = 1; b < 9; b++) if (k[b]) r |= 1 << (9 - b);
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    checks++;
    assert (md0 === '0 && md1 === '0) else begin
      errors++;
      $error("FAIL %s got nonzero buffer expected all zero", tag);
    end
  endtask

  task automatic stream_frame(input int base, input string tag);
    for (int i = 0; i < NW; i++) begin
      sample_in = DW'(base + i);
      sample_valid = 1'b1;
      step();
      if (i < NW - 1) chk({tag, "_nostart"}, {30'd0, start0, start1}, 32'd0);
    end
    sample_valid = 1'b0;
    chk({tag, "_start"}, {30'd0, start0, start1}, 32'd3);
    chk({tag, "_cnt"}, cnt0, 32'd512);
    step();
    chk({tag, "_start_once"}, {30'd0, start0, start1}, 32'd0);
  endtask

  task automatic finish_frame();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
  endtask

  initial begin
    int k, cyc, starts;
    logic seen_dead;
    n_rst = 1'b0; sample_in = '0; sample_valid = 1'b0;
    frame_restart = 1'b0; fft_done = 1'b0;

    // reset state
    #12;
    chk_zero("rst_buf");
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_start_busy", {30'd0, start0, busy0}, 32'd0);
    n_rst = 1'b1;
    step();
    chk("rst_ready", {30'd0, ready0, ready1}, 32'd3);

    // full linear frame 0..511
    for (int i = 0; i < NW; i++) begin
      sample_in = DW'(i); sample_valid = 1'b1;
      step();
      if (i < NW - 1) chk("f1_nostart", start0, 32'd0);
    end
    sample_valid = 1'b0;
    chk("f1_start", {30'd0, start0, start1}, 32'd3);
    chk("f1_ready", ready0, 32'd0);
    chk("f1_busy", busy0, 32'd1);
    for (int i = 0; i < NW; i++) chk("f1_word", md0[i], 32'(i));
    chk("rev_w0", md1[0], 32'h0);
    chk("rev_w2", md1[2], 32'h100);
    chk("rev_w3", md1[3], 32'h101);
    chk("rev_w256", md1[256], 32'h2);
    chk("rev_w511", md1[511], 32'h1ff);
    step();
    chk("wait_start_low", start0, 32'd0);
    chk("wait_busy", busy0, 32'd1);

    // valid held in WAIT_DONE is refused
    sample_in = 16'hDEAD; sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("wait_ready", {30'd0, ready0, ready1}, 32'd0);
    end
    chk("wait_cnt", cnt0, 32'd512);
    sample_valid = 1'b0;
    finish_frame();
    chk("done_ready", ready0, 32'd1);
    chk("done_busy", busy0, 32'd0);
    chk("done_cnt", cnt0, 32'd0);
    seen_dead = 1'b0;
    for (int i = 0; i < NW; i++) if (md0[i] == 16'hDEAD || md1[i] == 16'hDEAD) seen_dead = 1'b1;
    chk("no_dead", {31'd0, seen_dead}, 32'd0);
    chk("frozen_w7", md0[7], 32'd7);

    // partial frame then restart with a same-cycle word
    for (int i = 0; i < 100; i++) begin
      sample_in = DW'(16'h1000 + i); sample_valid = 1'b1;
      step();
    end
    chk("part_cnt", cnt0, 32'd100);
    chk("part_w99", md0[99], 32'h1063);
    sample_in = 16'hBEEF; frame_restart = 1'b1;
    step();
    frame_restart = 1'b0; sample_valid = 1'b0;
    chk("restart_cnt", cnt0, 32'd0);
    chk("restart_no_beef", md0[100], 32'd100);
    chk("restart_ready", ready0, 32'd1);
    stream_frame(16'h2000, "f2");
    chk("f2_w0", md0[0], 32'h2000);
    chk("f2_w100", md0[100], 32'h2064);
    chk("f2_w511", md0[511], 32'h21ff);
    finish_frame();

    // reset during WAIT_DONE
    stream_frame(16'h3000, "f3");
    chk("f3_busy", busy0, 32'd1);
    n_rst = 1'b0;
    #1;
    chk_zero("rst_wait_buf");
    chk("rst_wait_cnt", cnt0, 32'd0);
    chk("rst_wait_flags", {30'd0, start0, busy0}, 32'd0);
    n_rst = 1'b1;
    step();

    // reset at word 300 of a fill
    for (int i = 0; i < 300; i++) begin
      sample_in = DW'(16'h5000 + i); sample_valid = 1'b1;
      step();
    end
    chk("fill300_cnt", cnt0, 32'd300);
    n_rst = 1'b0; sample_valid = 1'b0;
    #1;
    chk_zero("rst_fill_buf");
    chk("rst_fill_cnt", cnt0, 32'd0);
    chk("rst_fill_flags", {30'd0, start0, busy0}, 32'd0);
    n_rst = 1'b1;
    step();

    // gated valid, stray fft_done during FILL
    k = 0; cyc = 0; starts = 0;
    while (k < NW && cyc < 4000) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_in = DW'(16'h4000 + k);
      fft_done = ($urandom_range(0, 3) == 0);
      if (sample_valid) k++;
      step();
      cyc++;
      if (start0) starts++;
      chk("rnd_start", start0, (k == NW) ? 32'd1 : 32'd0);
    end
    sample_valid = 1'b0; fft_done = 1'b0;
    chk("rnd_bound", k, 32'd512);
    for (int i = 0; i < 10; i++) begin
      step();
      if (start0) starts++;
    end
    chk("rnd_one_start", starts, 32'd1);
    chk("rnd_busy", busy0, 32'd1);
    for (int i = 0; i < NW; i++) chk("rnd_word", md0[i], 32'(16'h4000 + i));
    for (int i = 0; i < NW; i += 37) chk("rnd_rev", md1[rev_addr(i)], 32'(16'h4000 + i));
    finish_frame();
    chk("rnd_ready", ready0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Writer end of the FFT sample buffer. Accepts a serial stream of 16-bit samples over a valid/ready handshake and assembles them into the 512x16 frame consumed by the FFT core (the core's main_data input).
- Issues a one-cycle fft_start when the frame is complete.
- Holds the frame stable and refuses new samples until the core reports fft_done.
- Sits between the sample source and the FFT top-level.

Parameters:
- N_WORDS, 512: words per frame; interleaved real/imag, so 256 complex points; power of two.
- DATA_W, 16: sample word width.
- BIT_REVERSE, 0: when 1, the complex point index is bit-reversed on write; the real/imag select bit (LSB) is kept.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- sample_in  in  DATA_W  incoming sample word (real, imag, real, imag ...)
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  loader accepts a sample this cycle
- frame_restart  in  1  synchronous discard of the partially filled frame
- fft_done  in  1  FFT core finished the current frame (pulse or level)
- fft_start  out  1  one-cycle pulse: frame complete, core may start
- busy  out  1  frame handed to core, awaiting fft_done
- samples_loaded_count  out  log2(N_WORDS)+1  words written in current frame
- main_data  out  N_WORDS x DATA_W  frame buffer, packed [N_WORDS-1:0][DATA_W-1:0]

Behaviour:
- Reset (async, n_rst=0):
  - state=FILL, count=0, fft_start=0, busy=0, main_data all zero.
  - sample_ready=1 after reset is released.
  - Reset mid-operation aborts any frame or wait immediately.
- States: FILL, START, WAIT_DONE.
- FILL:
  - sample_ready=1.
  - A handshake occurs when sample_valid & sample_ready.
  - On handshake: write buffer[addr(count)] <= sample_in, count <= count+1.
  - The written word appears on main_data the next cycle (latency 1).
  - addr(count) = count when BIT_REVERSE=0.
  - addr(count) = {bitrev(count[msb:1]), count[0]} when BIT_REVERSE=1.
  - The handshake writing word N_WORDS-1 moves state to START. count reads N_WORDS in START and WAIT_DONE.
- START (exactly one cycle): fft_start=1, sample_ready=0, busy=1. Next state is WAIT_DONE.
- WAIT_DONE:
  - sample_ready=0, busy=1, buffer frozen.
  - When fft_done=1: next state FILL, count <= 0, busy deasserts the next cycle.
  - sample_ready is 1 in the cycle after fft_done is sampled.
- Buffer is never cleared except by reset. A new frame overwrites words in place.
- frame_restart:
  - In FILL: count <= 0 next cycle; any handshake in the same cycle is discarded (restart wins).
  - In START or WAIT_DONE: ignored.
- fft_done:
  - In FILL: ignored.
  - In START: ignored; only WAIT_DONE samples it, so a done level held from a prior frame is not a hazard, provided the core has dropped it by the time WAIT_DONE is entered. Level done is acceptable only under that condition.
- sample_valid while sample_ready=0: no write, count unchanged. The source holds data per the valid/ready rule.
- fft_start is never asserted twice per frame. It is never asserted for a partial frame.
- Throughput: one word per cycle in FILL. A full frame takes N_WORDS cycles plus START, plus WAIT_DONE for the core's latency.

Decomposition:
- Package fft_pkg holds:
  - localparams: N_WORDS, DATA_W, ADDR_W=$clog2(N_WORDS).
  - enum typedef loader_state_t {FILL, START, WAIT_DONE}.
  - typedef for the frame array.
- One sub-module, fft_bitrev_addr: a combinational index-to-address mapper, parameterised on ADDR_W and BIT_REVERSE. It is shared with later result-reader blocks.
- FSM, counter and buffer stay in fft_frame_loader.

Test Plan:
- Reset, then stream 512 words 0x0000..0x01FF with valid held high, BIT_REVERSE=0 -> main_data[i]=i; fft_start high exactly one cycle, the cycle after word 511; sample_ready=0; busy=1.
- In WAIT_DONE, hold sample_valid=1 with 0xDEAD for 20 cycles, then pulse fft_done -> buffer unchanged; sample_ready=1 the cycle after; count=0.
- BIT_REVERSE=1, stream words 0..511 -> main_data[2] holds 0x0100 (point 1 to point 128); main_data[3]=0x0101; main_data[0]=0; main_data[511]=511.
- Load 100 words, assert frame_restart together with a valid word 0xBEEF -> count=0; 0xBEEF not written; the next 512 words complete a frame and fft_start pulses once.
- Drop n_rst during WAIT_DONE and again at word 300 of a fill -> main_data all zero, count=0, busy=0, fft_start=0 immediately; a normal frame loads afterwards.
- Randomly gate sample_valid (~50%) and pulse fft_done during FILL -> all 512 words land in order; no spurious fft_start; exactly one fft_start per frame.
